// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file command sequencer.
package reg_file_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADD  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_S = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/rf_alu8.sv
// Combinational adder with carry-out used for the ADD command.
module rf_alu8 #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          carry
);

    localparam int unsigned SW = DW + 1;

    // Widen both operands so the carry lands in the top bit.
    always_comb begin
        {carry, sum} = SW'(a) + SW'(b);
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Command sequencer driving the 4 x 8-bit register file; one command in flight.
module reg_file_ctrl
    import reg_file_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] rnnn,
    output logic [DW-1:0] wrdddd,
    output logic          write_enable,
    input  logic [DW-1:0] rf_rdata,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_carry
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] opb_q, opb_d;
    logic          carry_q, carry_d;

    logic          cmd_ready_d;
    logic [AW-1:0] rnnn_d;
    logic [DW-1:0] wrdddd_d;
    logic          write_enable_d;
    logic          res_valid_d;
    logic [DW-1:0] res_data_d;
    logic          res_carry_d;

    logic [DW-1:0] alu_sum;
    logic          alu_carry;

    rf_alu8 #(.DW(DW)) u_alu (
        .a     (rf_rdata),
        .b     (opb_q),
        .sum   (alu_sum),
        .carry (alu_carry)
    );

    // State and registered outputs; outputs are computed for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_LOAD;
            rd_q         <= '0;
            opb_q        <= '0;
            carry_q      <= 1'b0;
            cmd_ready    <= 1'b0;
            rnnn         <= '0;
            wrdddd       <= '0;
            write_enable <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_carry    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            opb_q        <= opb_d;
            carry_q      <= carry_d;
            cmd_ready    <= cmd_ready_d;
            rnnn         <= rnnn_d;
            wrdddd       <= wrdddd_d;
            write_enable <= write_enable_d;
            res_valid    <= res_valid_d;
            res_data     <= res_data_d;
            res_carry    <= res_carry_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        opb_d       = opb_q;
        carry_d     = carry_q;
        rnnn_d      = rnnn;
        wrdddd_d    = wrdddd;
        res_data_d  = res_data;
        res_carry_d = res_carry;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = op_e'(cmd_op);
                    rd_d    = cmd_rd;
                    carry_d = 1'b0;
                    if (op_e'(cmd_op) == OP_LOAD) begin
                        state_d  = WR;
                        rnnn_d   = cmd_rd;
                        wrdddd_d = cmd_imm;
                    end else begin
                        state_d = RD_S;
                        rnnn_d  = cmd_rs;
                    end
                end
            end
            RD_S: begin
                opb_d = rf_rdata;
                case (op_q)
                    OP_MOV: begin
                        state_d  = WR;
                        rnnn_d   = rd_q;
                        wrdddd_d = rf_rdata;
                    end
                    OP_READ: begin
                        state_d     = RESP;
                        res_data_d  = rf_rdata;
                        res_carry_d = 1'b0;
                    end
                    default: begin
                        state_d = RD_D;
                        rnnn_d  = rd_q;
                    end
                endcase
            end
            RD_D: begin
                state_d  = WR;
                rnnn_d   = rd_q;
                wrdddd_d = alu_sum;
                carry_d  = alu_carry;
            end
            WR: begin
                state_d     = RESP;
                res_data_d  = wrdddd;
                res_carry_d = carry_q;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d    = (state_d == IDLE);
        write_enable_d = (state_d == WR);
        res_valid_d    = (state_d == RESP);
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl with a behavioural register file.
module tb_reg_file_ctrl;
    import reg_file_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs;
    logic [7:0] cmd_imm;
    logic [1:0] rnnn;
    logic [7:0] wrdddd;
    logic       write_enable;
    logic [7:0] rf_rdata;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] ed;
        logic       ec;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       c;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];

    logic [7:0] rf_mem [4];

    reg_file_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs       (cmd_rs),
        .cmd_imm      (cmd_imm),
        .rnnn         (rnnn),
        .wrdddd       (wrdddd),
        .write_enable (write_enable),
        .rf_rdata     (rf_rdata),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on the strobe edge.
    assign rf_rdata = rf_mem[rnnn];
    always @(posedge clk) begin
        if (write_enable) rf_mem[rnnn] <= wrdddd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command with res_ready high and check timing, write and result.
    task automatic run_cmd(input vec_t v);
        int         n;
        int         wcnt;
        int         wcyc;
        logic [1:0] waddr;
        logic [7:0] wdat;
        logic [1:0] rnnn_c1;
        bit         got;
        exp_t       e;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_rd    = v.rd;
        cmd_rs    = v.rs;
        cmd_imm   = v.imm;
        sb_q.push_back('{v.ed, v.ec});
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_rd    = 2'($urandom);
        cmd_rs    = 2'($urandom);
        cmd_imm   = 8'($urandom);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        n = 1; wcnt = 0; wcyc = 0; got = 1'b0;
        waddr = '0; wdat = '0; rnnn_c1 = rnnn;
        while (n <= 10) begin
            if (write_enable) begin
                wcnt++; wcyc = n; waddr = rnnn; wdat = wrdddd;
            end
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(v.lat));
        if (v.op == OP_READ) begin
            check("read_no_write", 32'(wcnt), 32'd0);
        end else begin
            check("write_count", 32'(wcnt), 32'd1);
            check("write_addr", 32'(waddr), 32'(v.rd));
            check("write_data", 32'(wdat), 32'(v.ed));
            check("write_cycle", 32'(wcyc), 32'(v.lat - 1));
        end
        if (v.op != OP_LOAD) check("rd_s_addr", 32'(rnnn_c1), 32'(v.rs));
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("res_data", 32'(res_data), 32'(e.d));
            check("res_carry", 32'(res_carry), 32'(e.c));
        end
        @(negedge clk);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("res_valid_after", 32'(res_valid), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rnnn", 32'(rnnn), 32'd0);
        check("rst_wrdddd", 32'(wrdddd), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_carry", 32'(res_carry), 32'd0);
    endtask

    initial begin
        int   n;
        int   bad;
        exp_t e;

        vecs[0]  = '{2'd0, 2'd2, 2'd0, 8'h5A, 8'h5A, 1'b0, 2};
        vecs[1]  = '{2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0, 2};
        vecs[2]  = '{2'd1, 2'd3, 2'd0, 8'h00, 8'h11, 1'b0, 3};
        vecs[3]  = '{2'd0, 2'd1, 2'd0, 8'hF0, 8'hF0, 1'b0, 2};
        vecs[4]  = '{2'd0, 2'd2, 2'd0, 8'h20, 8'h20, 1'b0, 2};
        vecs[5]  = '{2'd2, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 4};
        vecs[6]  = '{2'd2, 2'd2, 2'd2, 8'h00, 8'h40, 1'b0, 4};
        vecs[7]  = '{2'd3, 2'd0, 2'd1, 8'h00, 8'h10, 1'b0, 2};
        vecs[8]  = '{2'd2, 2'd3, 2'd3, 8'h00, 8'h22, 1'b0, 4};
        vecs[9]  = '{2'd3, 2'd0, 2'd3, 8'h00, 8'h22, 1'b0, 2};
        vecs[10] = '{2'd2, 2'd0, 2'd1, 8'h00, 8'h21, 1'b0, 4};
        vecs[11] = '{2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 2};
        vecs[12] = '{2'd2, 2'd0, 2'd0, 8'h00, 8'hFE, 1'b1, 4};
        vecs[13] = '{2'd3, 2'd0, 2'd0, 8'h00, 8'hFE, 1'b0, 2};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs    = '0;
        cmd_imm   = '0;
        res_ready = 1'b1;

        // Reset state, then cmd_ready rises on the first edge out of reset.
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // READ r1 with res_ready held low: result must stall with no RF writes.
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_rd = 2'd0; cmd_rs = 2'd1; cmd_imm = 8'h00;
        sb_q.push_back('{8'h10, 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!res_valid && n <= 10) begin
            @(negedge clk);
            n++;
        end
        check("stall_latency", 32'(n), 32'd2);
        e = sb_q.pop_front();
        bad = 0;
        repeat (5) begin
            if (!res_valid || res_data !== e.d || res_carry !== e.c || write_enable || cmd_ready) bad++;
            @(negedge clk);
        end
        check("stall_stable", 32'(bad), 32'd0);
        check("stall_data", 32'(res_data), 32'(e.d));
        res_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(cmd_ready), 32'd1);
        check("stall_release_valid", 32'(res_valid), 32'd0);

        // Reset during RD_D of ADD r1 += r2: no write and no response afterwards.
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 2'd1; cmd_rs = 2'd2; cmd_imm = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rd_d_addr", 32'(rnnn), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (write_enable || res_valid) bad++;
        end
        check("abort_no_activity", 32'(bad), 32'd0);
        check("abort_sb_empty", 32'(sb_q.size()), 32'd0);
        run_cmd('{2'd3, 2'd0, 2'd1, 8'h00, 8'h10, 1'b0, 2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Command sequencer that sits directly upstream of the 4 x 8-bit register file and drives its address, write-data and write-enable inputs. Accepts one register-transfer command at a time over a valid/ready handshake (LOAD immediate, MOV, ADD, READ), performs the needed register-file reads and the single write, then returns a result over a second valid/ready handshake. The register file's read-data output feeds back into this block.

## Interface
Parameters:
- DW, 8, data width; must match the register-file word width.
- AW, 2, register address width; 2^AW registers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  operation: 00 LOAD, 01 MOV, 10 ADD, 11 READ.
- cmd_rd  input  AW  destination register.
- cmd_rs  input  AW  source register.
- cmd_imm  input  DW  immediate for LOAD.
- rnnn  output  AW  register-file address.
- wrdddd  output  DW  register-file write data.
- write_enable  output  1  register-file write strobe.
- rf_rdata  input  DW  register-file read data for the register at rnnn; combinational.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts result.
- res_data  output  DW  result value.
- res_carry  output  1  ADD carry-out; 0 for other ops.

## Operation
- States: IDLE, RD_S, RD_D, WR, RESP.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch op, rd, rs and imm, and drop cmd_ready. LOAD goes to WR with wdata=imm. MOV, ADD and READ go to RD_S.
- RD_S: rnnn=rs; rf_rdata is captured into opb at the end of the cycle. MOV then goes to WR with wdata=opb. READ goes to RESP with res_data=opb. ADD goes to RD_D.
- RD_D: rnnn=rd; compute the 9-bit sum = rf_rdata + opb. Then go to WR with wdata=sum[7:0] and carry=sum[8].
- WR: rnnn=rd, wrdddd=wdata, write_enable=1 for exactly this one cycle. Then go to RESP with res_data=wdata.
- RESP: res_valid=1; res_data and res_carry are held stable until res_ready is sampled high. Then go to IDLE and reassert cmd_ready.
- Arithmetic: ADD wraps modulo 2^DW, and the carry is reported on res_carry. ADD with rd==rs doubles the register.
- Outside WR, write_enable=0 and wrdddd holds its last value. No write is ever issued for READ.

## Timing
- All outputs are registered. rnnn is updated on the edge that enters a state, so it is stable for the whole state.
- Latency from accept edge (cycle 0) to res_valid rising:
  - LOAD: 2 cycles.
  - MOV: 3 cycles.
  - ADD: 4 cycles.
  - READ: 2 cycles.
- The write strobe occurs in the cycle just before res_valid for LOAD, MOV and ADD. Write data is therefore committed before the result is presented.
- Back-to-back commands: after the RESP handshake, cmd_ready is 1 in the next cycle. This gives a minimum gap of one cycle between res handshake and next accept.
- While cmd_ready=0, cmd_valid is ignored and the command inputs are don't-care.
- res_ready held low: the block stalls in RESP indefinitely, with no further register-file activity.
- Reset values (rst_n low at an edge):
  - state=IDLE.
  - cmd_ready=0, rising to 1 on the first edge with rst_n high.
  - rnnn=0, wrdddd=0, write_enable=0.
  - res_valid=0, res_data=0, res_carry=0.
- Reset mid-operation: any pending command is discarded, no write is issued after the reset edge, and no response is produced.

## Structure
- Shared package reg_file_pkg holds:
  - the DW/AW defaults,
  - the cmd_op encodings (OP_LOAD, OP_MOV, OP_ADD, OP_READ),
  - the state enumeration.
- One sub-module, rf_alu8: combinational 8-bit add with carry-out, instantiated once for the RD_D computation. Everything else is in the single FSM module.

## Test plan
- Reset, then LOAD rd=2 imm=0x5A -> write_enable pulses 1 cycle with rnnn=2, wrdddd=0x5A. Then res_valid with res_data=0x5A, res_carry=0, 2 cycles after accept.
- LOAD r0=0x11, then MOV rd=3 rs=0 -> RD_S shows rnnn=0, WR shows rnnn=3 wrdddd=0x11, res_data=0x11.
- LOAD r1=0xF0, r2=0x20, then ADD rd=1 rs=2 -> wrdddd=0x10 to r1, res_data=0x10, res_carry=1, 4 cycles after accept. Also ADD rd=rs=2 -> 0x40, carry 0.
- READ rs=1 with res_ready held low for 5 cycles -> no write_enable pulse, res_valid and res_data=0x10 stay stable, cmd_ready=0 throughout. Release res_ready -> cmd_ready=1 on the next cycle.
- Assert rst_n=0 during the RD_D cycle of an ADD -> no write_enable afterwards, res_valid=0, and all outputs take their reset values.
